// File: rtl/mmio_store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// mmio_store_buffer_pkg
//   Shared memory-map constants and types for the core-side store buffer.
//   Holds the default MMIO base and data-RAM address width, the peripheral
//   offset map, the queued MMIO entry layout and small helper functions.
//   No ports (package).
// -----------------------------------------------------------------------------
package mmio_store_buffer_pkg;

    localparam int unsigned DEPTH_DEFAULT     = 32'd8;
    localparam int unsigned RAM_AW_DEFAULT    = 32'd10;
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_1000;

    // Peripheral register offsets relative to the MMIO base.
    typedef enum logic [31:0] {
        IO_SEG = 32'd0,
        IO_LED = 32'd1
    } io_offset_e;

    // One queued MMIO store: offset from the MMIO base plus its data word.
    typedef struct packed {
        logic [31:0] offset;
        logic [31:0] data;
    } mmio_entry_t;

    localparam int unsigned ENTRY_W = $bits(mmio_entry_t);

    // Address decode: everything at or above the base belongs to the peripheral.
    function automatic logic is_mmio(input logic [31:0] addr, input logic [31:0] base);
        return (addr >= base);
    endfunction

    // Saturating increment for the 16-bit drop counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : (value + 16'd1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with wrap-bit pointers. A push into a full FIFO is
//   accepted only when a pop happens in the same cycle (the slot being read
//   out is the slot being written).
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset, clears pointers
//   push_req  in   request to enqueue wdata
//   wdata     in   entry to enqueue
//   rd_ready  in   consumer accepts the head entry
//   rd_valid  out  head entry available (not empty)
//   rdata     out  head entry
//   full      out  DEPTH entries held
//   empty     out  no entries held
//   pop       out  head entry consumed this cycle
//   push      out  push_req accepted this cycle
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 32'd64,
    parameter int unsigned DEPTH = 32'd8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_req,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             pop,
    output logic             push
);

    localparam int unsigned     AW       = $clog2(DEPTH);
    localparam int unsigned     PW       = AW + 32'd1;
    localparam logic [PW-1:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [PW-1:0]   FULL_XOR = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;

    // Status and handshake decode from the registered pointers.
    always_comb begin
        w_full  = ((r_wr_ptr ^ r_rd_ptr) == FULL_XOR);
        w_empty = (r_wr_ptr == r_rd_ptr);
        w_pop   = ~w_empty & rd_ready;
        // When full, the write lands in the slot freed by the concurrent pop.
        w_push  = push_req & (~w_full | w_pop);
    end

    // Pointer update; pointers wrap modulo 2*DEPTH by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata    = r_mem[r_rd_ptr[AW-1:0]];
    assign rd_valid = ~w_empty;
    assign full     = w_full;
    assign empty    = w_empty;
    assign pop      = w_pop;
    assign push     = w_push;

endmodule

// File: rtl/mmio_store_buffer.sv
// -----------------------------------------------------------------------------
// mmio_store_buffer
//   Sits on the core data port and splits every store by address:
//   stores below MMIO_BASE go out as a registered data-RAM write (latency 1);
//   stores at or above MMIO_BASE are queued and drained over valid/ready.
//   The core cannot stall, so an MMIO store hitting a full queue (with no
//   concurrent pop) is dropped and the sticky overflow flag is set.
//   Optional feature macro: MMIO_DROP_CNT_EN adds a saturating 16-bit
//   drop counter output (drop_cnt).
// Ports:
//   clk, rst             clock (rising) and async active-high reset
//   mem_addr/data/we     store from the core
//   ram_we/addr/wdata    registered data-RAM write
//   io_valid/ready       handshake toward the peripheral
//   io_addr/io_data      head entry: offset from MMIO_BASE and data
//   full/empty           queue status
//   overflow             sticky drop flag, cleared only by rst
//   drop_cnt             (MMIO_DROP_CNT_EN only) dropped-store count
// -----------------------------------------------------------------------------
module mmio_store_buffer
    import mmio_store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH     = DEPTH_DEFAULT,
    parameter int unsigned RAM_AW    = RAM_AW_DEFAULT,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_data,
    input  logic              mem_we,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              io_valid,
    input  logic              io_ready,
    output logic [31:0]       io_addr,
    output logic [31:0]       io_data,
    output logic              full,
    output logic              empty,
    output logic              overflow
`ifdef MMIO_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);

    logic              w_mmio_sel;
    logic              w_ram_hit;
    logic              w_mmio_hit;
    logic              w_drop;
    mmio_entry_t       w_entry;
    mmio_entry_t       w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;

    logic              r_ram_we;
    logic [RAM_AW-1:0] r_ram_addr;
    logic [31:0]       r_ram_wdata;
    logic              r_overflow;

    // Address classification and MMIO entry formation.
    always_comb begin
        w_mmio_sel     = is_mmio(mem_addr, MMIO_BASE);
        w_ram_hit      = mem_we & ~w_mmio_sel;
        w_mmio_hit     = mem_we &  w_mmio_sel;
        w_entry.offset = mem_addr - MMIO_BASE;
        w_entry.data   = mem_data;
        w_drop         = w_mmio_hit & w_full & ~w_pop;
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_req (w_mmio_hit),
        .wdata    (w_entry),
        .rd_ready (io_ready),
        .rd_valid (io_valid),
        .rdata    (w_head),
        .full     (w_full),
        .empty    (w_empty),
        .pop      (w_pop),
        .push     (w_push)
    );

    // Data-RAM register stage; address/data hold between RAM stores.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_we    <= 1'b0;
            r_ram_addr  <= {RAM_AW{1'b0}};
            r_ram_wdata <= 32'd0;
        end else begin
            r_ram_we <= w_ram_hit;
            if (w_ram_hit) begin
                // Upper address bits are ignored, so RAM addresses wrap.
                r_ram_addr  <= mem_addr[RAM_AW-1:0];
                r_ram_wdata <= mem_data;
            end
        end
    end

    // Sticky overflow flag; set on any dropped MMIO store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef MMIO_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    // Saturating count of dropped MMIO stores.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= 16'd0;
        end else if (w_drop) begin
            r_drop_cnt <= sat_inc16(r_drop_cnt);
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign io_addr   = w_head.offset;
    assign io_data   = w_head.data;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = r_overflow;

    // Accepted-push indication is available for observation but not needed here.
    logic w_unused;
    assign w_unused = w_push;

endmodule

// File: tb/tb_mmio_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_mmio_store_buffer
//   Directed stimulus with a queue-based reference model of the store buffer.
//   A negedge process compares every DUT output against the model each cycle;
//   hand-computed literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_mmio_store_buffer;

    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_data = 32'd0;
    logic        mem_we = 1'b0;
    logic        io_ready = 1'b0;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        io_valid;
    logic [31:0] io_addr;
    logic [31:0] io_data;
    logic        full;
    logic        empty;
    logic        overflow;
`ifdef MMIO_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] mq_off[$];
    logic [31:0] mq_dat[$];
    logic        m_ram_we;
    logic [9:0]  m_ram_addr;
    logic [31:0] m_ram_wdata;
    logic        m_ovf;
    logic [15:0] m_cnt;

    mmio_store_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .io_valid  (io_valid),
        .io_ready  (io_ready),
        .io_addr   (io_addr),
        .io_data   (io_data),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
`ifdef MMIO_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq_off.delete();
        mq_dat.delete();
        m_ram_we    = 1'b0;
        m_ram_addr  = 10'd0;
        m_ram_wdata = 32'd0;
        m_ovf       = 1'b0;
        m_cnt       = 16'd0;
    endtask

    // Applies one clock edge of the documented behaviour to the model.
    task automatic model_update();
        int  sz;
        bit  pop;
        logic [31:0] a;
        if (rst) begin
            model_reset();
        end else begin
            sz  = mq_off.size();
            pop = (sz != 0) && io_ready;
            a   = mem_addr;
            if (mem_we && (a < BASE)) begin
                m_ram_we    = 1'b1;
                m_ram_addr  = a[9:0];
                m_ram_wdata = mem_data;
            end else begin
                m_ram_we = 1'b0;
            end
            if (pop) begin
                void'(mq_off.pop_front());
                void'(mq_dat.pop_front());
            end
            if (mem_we && (a >= BASE)) begin
                if ((sz < DEPTH) || pop) begin
                    mq_off.push_back(a - BASE);
                    mq_dat.push_back(mem_data);
                end else begin
                    m_ovf = 1'b1;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_we   = 1'b1;
        mem_addr = a;
        mem_data = d;
    endtask

    // Idle cycle: strobe low while address still points into MMIO space.
    task automatic idle();
        mem_we   = 1'b0;
        mem_addr = 32'h0000_1FF0;
        mem_data = 32'hDEAD_BEEF;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("io_valid", io_valid, mq_off.size() != 0);
        chk("full", full, mq_off.size() == DEPTH);
        chk("empty", empty, mq_off.size() == 0);
        chk("overflow", overflow, m_ovf);
        chk("ram_we", ram_we, m_ram_we);
        chk("ram_addr", ram_addr, m_ram_addr);
        chk("ram_wdata", ram_wdata, m_ram_wdata);
        if (mq_off.size() != 0) begin
            chk("io_addr", io_addr, mq_off[0]);
            chk("io_data", io_data, mq_dat[0]);
        end
`ifdef MMIO_DROP_CNT_EN
        chk("drop_cnt", drop_cnt, m_cnt);
`endif
    end

    initial begin
        model_reset();
        idle();
        tick();
        tick();
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", ram_addr, 10'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_io_valid", io_valid, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_overflow", overflow, 1'b0);
        rst = 1'b0;
        tick();

        // 1. RAM stores, including the last RAM address and a wrapping address
        store(32'h10, 32'hCAFE);
        tick();
        idle();
        chk("t1_ram_we", ram_we, 1'b1);
        chk("t1_ram_addr", ram_addr, 10'h010);
        chk("t1_ram_wdata", ram_wdata, 32'hCAFE);
        chk("t1_io_valid", io_valid, 1'b0);
        tick();
        chk("t1_hold_addr", ram_addr, 10'h010);
        chk("t1_we_low", ram_we, 1'b0);
        store(32'h0000_0FFF, 32'h1111);
        tick();
        store(32'h0000_0C05, 32'h2222);
        tick();
        chk("t1_wrap_addr", ram_addr, 10'h005);
        idle();
        tick();

        // 2. MMIO store held until accepted
        io_ready = 1'b0;
        store(32'h1004, 32'h5A);
        tick();
        idle();
        chk("t2_io_valid", io_valid, 1'b1);
        chk("t2_io_addr", io_addr, 32'd4);
        chk("t2_io_data", io_data, 32'h5A);
        for (int i = 0; i < 3; i++) tick();
        chk("t2_stable_addr", io_addr, 32'd4);
        chk("t2_stable_data", io_data, 32'h5A);
        io_ready = 1'b1;
        tick();
        io_ready = 1'b0;
        chk("t2_popped", io_valid, 1'b0);

        // 4. Full FIFO, push and pop in the same cycle
        for (int i = 0; i < DEPTH; i++) begin
            store(BASE + 32'(4 * i), 32'h100 + 32'(i));
            tick();
        end
        chk("t4_full", full, 1'b1);
        store(BASE + 32'h40, 32'h200);
        io_ready = 1'b1;
        tick();
        idle();
        chk("t4_still_full", full, 1'b1);
        chk("t4_no_ovf", overflow, 1'b0);
        for (int i = 1; i < DEPTH; i++) begin
            chk("t4_order", io_data, 32'h100 + 32'(i));
            tick();
        end
        chk("t4_last", io_data, 32'h200);
        chk("t4_last_addr", io_addr, 32'h40);
        tick();
        chk("t4_empty", empty, 1'b1);
        io_ready = 1'b0;

        // 5. Wrap: 20 push/pop pairs
        io_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            store(BASE + 32'(8 * i), 32'h300 + 32'(i));
            tick();
        end
        idle();
        chk("t5_tail", io_data, 32'h313);
        chk("t5_not_full", full, 1'b0);
        tick();
        chk("t5_empty", empty, 1'b1);
        io_ready = 1'b0;

        // 3. Fill, drop the ninth, drain in order
        for (int i = 0; i < DEPTH; i++) begin
            store(BASE + 32'(i), 32'(i));
            tick();
        end
        chk("t3_full", full, 1'b1);
        store(BASE + 32'h20, 32'd99);
        tick();
        idle();
        chk("t3_overflow", overflow, 1'b1);
`ifdef MMIO_DROP_CNT_EN
        chk("t3_drop_cnt", drop_cnt, 16'd1);
`endif
        io_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t3_drain", io_data, 32'(i));
            tick();
        end
        chk("t3_empty", empty, 1'b1);
        io_ready = 1'b0;

        // 6. Asynchronous reset mid-drain
        for (int i = 0; i < 3; i++) begin
            store(BASE + 32'h10 + 32'(i), 32'hA0 + 32'(i));
            tick();
        end
        store(32'h20, 32'h55);
        tick();
        idle();
        chk("t6_pre_ram_we", ram_we, 1'b1);
        io_ready = 1'b1;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t6_io_valid", io_valid, 1'b0);
        chk("t6_empty", empty, 1'b1);
        chk("t6_overflow", overflow, 1'b0);
        chk("t6_ram_we", ram_we, 1'b0);
        tick();
        rst = 1'b0;
        io_ready = 1'b0;
        tick();
        store(32'h1008, 32'h77);
        tick();
        idle();
        chk("t6_new_addr", io_addr, 32'd8);
        chk("t6_new_data", io_data, 32'h77);
        io_ready = 1'b1;
        tick();
        chk("t6_drained", empty, 1'b1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
